fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage that replaces the PC / PC-adder / IF-ID register group.
//  Owns the fetch PC and drives the synchronous instruction SRAM (1-cycle read latency).
//  Buffers fetched words in a DEPTH-entry prefetch queue; decode consumes them via valid/ready.
//  Decode redirects it on taken branches, flushing the queue and any in-flight read.
// PARAMETERS
//  WIDTH      32  data/PC width in bits
//  DEPTH      4   prefetch queue entries; power of two, >= 2
//  ADDR_BITS  11  instruction SRAM word-address width
//  RESET_PC   0   fetch PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk           in   1          clock; all state updates on posedge
//  rst           in   1          synchronous reset, active-high
//  IMEM_REQ      out  1          read strobe: SRAM read this cycle
//  IMEM_ADDR     out  ADDR_BITS  word address = fetch_pc[ADDR_BITS+1:2]
//  IMEM_Q        in   WIDTH      SRAM data, valid the cycle after IMEM_REQ
//  REDIRECT      in   1          taken branch from decode: flush and restart
//  REDIRECT_PC   in   WIDTH      new fetch PC; bits [1:0] ignored, treated as 00
//  INSTR_VALID   out  1          INSTR / INSTR_PC hold a fetched instruction
//  INSTR_READY   in   1          decode accepts; transfer = VALID & READY
//  INSTR         out  WIDTH      instruction word
//  INSTR_PC      out  WIDTH      byte address of INSTR
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, count=0, rd/wr ptr=0, inflight=0, IMEM_REQ=0, INSTR_VALID=0.
//  Outputs are forced inactive in the cycle rst is high, including mid-operation.
//  Issue rule: IMEM_REQ = !rst & !REDIRECT & (count + inflight < DEPTH).
//  On issue: inflight<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^WIDTH).
//  Response: in the cycle after issue (inflight=1), {req_pc, IMEM_Q} is pushed unless killed.
//  The issue rule guarantees a free slot, so a push never overflows.
//  Pop: a transfer removes the head entry. Push and pop in the same cycle leave count unchanged.
//  Pointers wrap modulo DEPTH. Full: count==DEPTH, so no issue. Empty: INSTR_VALID=0.
//  While INSTR_VALID=1 and INSTR_READY=0, INSTR and INSTR_PC hold stable.
//  REDIRECT cycle:
//   - queue cleared (count<=0, ptrs<=0); fetch_pc<=REDIRECT_PC & ~3; no issue.
//   - any response arriving in this cycle, or the next one, is discarded (kill flag).
//   - a transfer completing in the same cycle counts as accepted; REDIRECT has priority
//     over any push in that cycle.
//  Redirect latency: REDIRECT at t -> IMEM_REQ for the new PC at t+1
//   -> first INSTR_VALID at t+3 (t+2 with bypass).
//  Back-to-back REDIRECTs: the last one wins; each restarts the sequence above.
//  Steady state: one instruction per cycle while decode stays ready.
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//   - when queue empty and a live response arrives, INSTR_VALID=1 with INSTR=IMEM_Q
//     and INSTR_PC=req_pc combinationally in that cycle.
//   - if INSTR_READY=1, the word is consumed and not pushed; otherwise it is pushed.
//  FETCH_BYPASS_EN undefined:
//   - every response is pushed; INSTR_VALID rises at the earliest the cycle after the response.
// STRUCTURE
//  Package pipeline_pkg:
//   - typedef fetch_entry_t {logic [WIDTH-1:0] pc; logic [WIDTH-1:0] instr;}
//   - localparam NOP_INSTR = 32'h0000_0013
//   - localparam PC_STEP = 4
//  Sub-module fetch_fifo: DEPTH x fetch_entry_t; push, pop, clear, count, head outputs;
//   sync clear has priority over push.
//  Top level holds fetch_pc, inflight, kill flag, issue logic and the bypass mux.
// TESTING
//  1 reset, RESET_PC=0x100, INSTR_READY=1 -> IMEM_ADDR 0x40,0x41,0x42...;
//    INSTR_PC 0x100,0x104... one per cycle.
//  2 INSTR_READY=0 for 10 cycles -> exactly DEPTH=4 requests issued, then IMEM_REQ=0;
//    INSTR/INSTR_PC stable; resume -> no lost or duplicated PCs.
//  3 REDIRECT with REDIRECT_PC=0x203 while queue holds 3 entries and a read is in flight
//    -> old entries and response dropped; next INSTR_PC=0x200 at t+3 (t+2 bypass).
//  4 REDIRECT on two consecutive cycles (0x300, then 0x400)
//    -> no 0x300 instruction delivered; first INSTR_PC=0x400.
//  5 rst asserted mid-stream with a full queue -> next cycle INSTR_VALID=0, IMEM_REQ=0;
//    restart from RESET_PC.
//  6 fetch_pc=0xFFFF_FFFC, WIDTH=32 -> next INSTR_PC=0x0000_0000 (wrap);
//    compare queue against a scoreboard under random READY for 10k cycles.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants for the pipeline.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instr}; synchronous clear wins over push and pop.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the 1-cycle SRAM and queues words for decode.
// Define FETCH_BYPASS_EN to hand a live SRAM response straight to decode when the queue is empty.
module fetch_prefetch_unit
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int ADDR_BITS = 11,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 IMEM_REQ,
  output logic [ADDR_BITS-1:0] IMEM_ADDR,
  input  logic [WIDTH-1:0]     IMEM_Q,
  input  logic                 REDIRECT,
  input  logic [WIDTH-1:0]     REDIRECT_PC,
  output logic                 INSTR_VALID,
  input  logic                 INSTR_READY,
  output logic [WIDTH-1:0]     INSTR,
  output logic [WIDTH-1:0]     INSTR_PC
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;
  logic             inflight;
  logic             kill;
  logic [CW-1:0]    count;
  logic [CW-1:0]    occupancy;
  entry_t           head;
  entry_t           resp_entry;
  logic             issue;
  logic             live_resp;
  logic             bypass;
  logic             push;
  logic             pop;

  // An in-flight read already owns a slot, so a response can always be pushed.
  assign occupancy  = count + CW'(inflight);
  assign issue      = !rst && !REDIRECT && (occupancy < CW'(DEPTH));
  assign live_resp  = inflight && !kill && !REDIRECT;
  assign resp_entry = '{pc: req_pc, instr: IMEM_Q};

`ifdef FETCH_BYPASS_EN
  assign bypass = live_resp && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push      = live_resp && !(bypass && INSTR_READY);
  assign pop       = !rst && (count != '0) && INSTR_READY;
  assign IMEM_REQ  = issue;
  assign IMEM_ADDR = fetch_pc[ADDR_BITS+1:2];

  always_comb begin
    INSTR_VALID = 1'b0;
    INSTR       = WIDTH'(NOP_INSTR);
    INSTR_PC    = '0;
    if (!rst) begin
      if (count != '0) begin
        INSTR_VALID = 1'b1;
        INSTR       = head.instr;
        INSTR_PC    = head.pc;
      end else if (bypass) begin
        INSTR_VALID = 1'b1;
        INSTR       = IMEM_Q;
        INSTR_PC    = req_pc;
      end
    end
  end

  // A redirect blocks issue, so the kill flag only has to cover the response slot after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= REDIRECT;
      if (REDIRECT) begin
        fetch_pc <= REDIRECT_PC & ~WIDTH'(3);
      end else if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (REDIRECT),
    .push  (push),
    .pop   (pop),
    .wdata (resp_entry),
    .head  (head),
    .count (count)
  );

endmodule
